// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the architectural PC, issues one outstanding
// fetch at a time to instruction memory, and holds the fetched word in an
// output register with decoded field slices for the controller.
module ifetch_unit #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [6:0]    opcode,
  output logic [2:0]    func3,
  output logic [6:0]    func7,
  output logic [4:0]    rd,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2
);

  typedef enum logic [1:0] {
    S_REQ_PENDING = 2'd0,
    S_REQ         = 2'd1,
    S_WAIT        = 2'd2,
    S_OUT         = 2'd3
  } state_t;

  localparam logic [DW-1:0] NOP_INSTR = DW'(32'h0000_0013);

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_addr_q;
  logic          req_valid_q;
  logic          kill;
  logic          instr_valid_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] pc_q;

  logic [AW-1:0] redirect_tgt;
  logic [AW-1:0] pc_seq;

  // Redirect targets are word aligned; sequential PC wraps modulo 2^AW.
  assign redirect_tgt = redirect_pc & ~AW'(3);
  assign pc_seq       = pc_q + AW'(4);

  // Fetch FSM: request, wait for the single outstanding response, present it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ_PENDING;
      fetch_pc      <= RESET_PC;
      req_addr_q    <= RESET_PC;
      req_valid_q   <= 1'b0;
      kill          <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_q          <= RESET_PC;
    end else begin
      case (state)
        S_REQ_PENDING: begin
          // No request has been issued yet, so a redirect can retarget it.
          state       <= S_REQ;
          req_valid_q <= 1'b1;
          if (redirect_valid) begin
            fetch_pc   <= redirect_tgt;
            req_addr_q <= redirect_tgt;
          end
        end
        S_REQ: begin
          // The presented address is frozen; a redirect only marks the
          // eventual response as stale.
          if (redirect_valid) begin
            kill     <= 1'b1;
            fetch_pc <= redirect_tgt;
          end
          if (imem_req_ready) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill || redirect_valid) begin
              kill        <= 1'b0;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
              if (redirect_valid) begin
                fetch_pc   <= redirect_tgt;
                req_addr_q <= redirect_tgt;
              end else begin
                req_addr_q <= fetch_pc;
              end
            end else begin
              instr_q       <= imem_rsp_data;
              pc_q          <= req_addr_q;
              instr_valid_q <= 1'b1;
              state         <= S_OUT;
            end
          end else if (redirect_valid) begin
            kill     <= 1'b1;
            fetch_pc <= redirect_tgt;
          end
        end
        S_OUT: begin
          // Redirect wins over stall; otherwise hold until consumed.
          if (redirect_valid) begin
            instr_valid_q <= 1'b0;
            fetch_pc      <= redirect_tgt;
            req_addr_q    <= redirect_tgt;
            req_valid_q   <= 1'b1;
            state         <= S_REQ;
          end else if (!stall) begin
            instr_valid_q <= 1'b0;
            fetch_pc      <= pc_seq;
            req_addr_q    <= pc_seq;
            req_valid_q   <= 1'b1;
            state         <= S_REQ;
          end
        end
        default: begin
          state       <= S_REQ_PENDING;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc             = pc_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign func3  = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign func7  = instr_q[31:25];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed stimulus against a bench-side memory
// responder, a cycle-by-cycle program-order reference, and literal checks.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  // Second instance with a reset PC at the top of the address space.
  logic        rsp_valid2;
  logic [31:0] rsp_data2;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [6:0]  opcode2;
  logic [2:0]  func3_2;
  logic [6:0]  func7_2;
  logic [4:0]  rd2;
  logic [4:0]  rs1_2;
  logic [4:0]  rs2_2;

  int n_vec  = 0;
  int n_miss = 0;
  int rsp_delay = 0;

  ifetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  ifetch_unit #(.AW(32), .DW(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr2), .imem_rsp_valid(rsp_valid2),
    .imem_rsp_data(rsp_data2), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid2),
    .instr(instr2), .pc(pc2), .opcode(opcode2), .func3(func3_2),
    .func7(func7_2), .rd(rd2), .rs1(rs1_2), .rs2(rs2_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory responder for dut: accepts on valid&&ready, answers rsp_delay
  // cycles after the cycle following acceptance.
  initial begin : mem1
    logic        acc;
    logic [31:0] a;
    logic        pend;
    logic [31:0] pa;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    pend = 1'b0;
    pa   = 32'h0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready && !rst;
      a   = imem_req_addr;
      @(posedge clk);
      #2;
      if (acc) begin
        pend = 1'b1;
        cnt  = rsp_delay;
        pa   = a;
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pa);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Zero-wait responder for dut2.
  initial begin : mem2
    logic        acc;
    logic [31:0] a;
    rsp_valid2 = 1'b0;
    rsp_data2  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      acc = req_valid2 && imem_req_ready && !rst;
      a   = req_addr2;
      @(posedge clk);
      #2;
      rsp_valid2 = acc;
      rsp_data2  = acc ? mem_word(a) : 32'hDEAD_BEEF;
    end
  end

  // Program-order reference: which PC must be presented next, and what the
  // handshake rules require of the following cycle.
  initial begin : model
    logic [31:0] exp_pc;
    logic [31:0] w;
    logic [31:0] held_addr;
    logic        exp_hold;
    logic        exp_drop;
    logic        req_hold;
    exp_pc    = 32'h0;
    held_addr = 32'h0;
    exp_hold  = 1'b0;
    exp_drop  = 1'b0;
    req_hold  = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_hold) chk("m_stall_hold", {31'b0, instr_valid}, 32'd1);
      if (exp_drop) chk("m_valid_drop", {31'b0, instr_valid}, 32'd0);
      if (req_hold) begin
        chk("m_req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
        chk("m_req_addr_hold", imem_req_addr, held_addr);
      end
      chk("m_one_outstanding", {31'b0, instr_valid && imem_req_valid}, 32'd0);
      if (instr_valid === 1'b1) begin
        w = mem_word(exp_pc);
        chk("m_pc", pc, exp_pc);
        chk("m_instr", instr, w);
        chk("m_fields", {opcode, func3, func7, rd, rs1, rs2},
            {w[6:0], w[14:12], w[31:25], w[11:7], w[19:15], w[24:20]});
      end
      if (rst) begin
        exp_pc   = 32'h0;
        exp_hold = 1'b0;
        exp_drop = 1'b0;
        req_hold = 1'b0;
      end else begin
        exp_hold  = instr_valid && stall && !redirect_valid;
        exp_drop  = instr_valid && (redirect_valid || !stall);
        req_hold  = imem_req_valid && !imem_req_ready;
        held_addr = imem_req_addr;
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        else if (instr_valid && !stall) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    smp();
    while (instr_valid !== 1'b1 && n < maxc) begin
      next();
      smp();
      n++;
    end
    chk("instr_valid_seen", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input int maxc, input bit chk_iv);
    int   n;
    logic spur;
    n = 0;
    spur = 1'b0;
    smp();
    while (imem_req_valid !== 1'b1 && n < maxc) begin
      if (instr_valid !== 1'b0) spur = 1'b1;
      next();
      smp();
      n++;
    end
    chk("req_seen", {31'b0, imem_req_valid}, 32'd1);
    if (chk_iv) chk("no_spurious_valid", {31'b0, spur}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;

    // Reset state
    next();
    smp();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    next();
    rst = 1'b0;

    // First fetch: no request in cycle 0, request in cycle 1, valid in cycle 3
    smp();
    chk("c0_no_req", {31'b0, imem_req_valid}, 32'd0);
    next(); smp();
    chk("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c1_req_addr", imem_req_addr, 32'h0);
    next(); smp();
    chk("c2_not_valid", {31'b0, instr_valid}, 32'd0);
    next(); smp();
    chk("c3_valid", {31'b0, instr_valid}, 32'd1);
    chk("c3_instr", instr, 32'h0050_0093);
    chk("c3_opcode", {25'b0, opcode}, 32'h13);
    chk("c3_rd", {27'b0, rd}, 32'd1);
    chk("c3_rs1", {27'b0, rs1}, 32'd0);
    chk("c3_rs2", {27'b0, rs2}, 32'd5);
    chk("c3_func3", {29'b0, func3}, 32'd0);
    chk("c3_func7", {25'b0, func7}, 32'd0);
    chk("c3_pc", pc, 32'h0);
    chk("wrap_c3_valid", {31'b0, instr_valid2}, 32'd1);
    chk("wrap_c3_pc", pc2, 32'hFFFF_FFFC);
    next(); smp();
    chk("c4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c4_req_addr", imem_req_addr, 32'h4);
    chk("wrap_next_addr", req_addr2, 32'h0000_0000);
    chk("wrap_req_valid", {31'b0, req_valid2}, 32'd1);

    // Stall hold for 5 cycles with a live instruction
    next();
    stall = 1'b1;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, 32'h4);
      chk("stall_instr", instr, mem_word(32'h4));
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
      next();
      smp();
    end

    // Release stall while memory refuses requests for 4 cycles
    next();
    stall = 1'b0;
    imem_req_ready = 1'b0;
    next();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("nrdy_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("nrdy_req_addr", imem_req_addr, 32'h8);
      next();
    end
    imem_req_ready = 1'b1;
    wait_valid(10);
    chk("after_stall_pc", pc, 32'h8);

    // Redirect while waiting on a slow response
    next();
    rsp_delay = 2;
    wait_req(10, 1'b0);
    chk("wait_redir_old_addr", imem_req_addr, 32'hC);
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    next();
    redirect_valid = 1'b0;
    rsp_delay      = 0;
    wait_req(10, 1'b1);
    chk("wait_redir_addr", imem_req_addr, 32'h100);
    wait_valid(10);
    chk("wait_redir_pc", pc, 32'h100);

    // Redirect in the same cycle as the response
    wait_req(10, 1'b0);
    chk("same_old_addr", imem_req_addr, 32'h104);
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    next();
    redirect_valid = 1'b0;
    stall          = 1'b1;
    wait_req(10, 1'b1);
    chk("same_redir_addr", imem_req_addr, 32'h200);
    wait_valid(10);
    chk("same_redir_pc", pc, 32'h200);

    // Redirect beats stall in output state, then redirect an unaccepted request
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0303;
    imem_req_ready = 1'b0;
    next();
    redirect_pc    = 32'h0000_0400;
    stall          = 1'b0;
    smp();
    chk("out_redir_drop", {31'b0, instr_valid}, 32'd0);
    chk("out_redir_addr", imem_req_addr, 32'h300);
    next();
    redirect_valid = 1'b0;
    smp();
    chk("req_redir_stable", imem_req_addr, 32'h300);
    chk("req_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    next();
    imem_req_ready = 1'b1;
    smp();
    next();
    wait_req(10, 1'b1);
    chk("req_redir_addr", imem_req_addr, 32'h400);
    wait_valid(10);
    chk("req_redir_pc", pc, 32'h400);

    // Reset while a response is in flight
    next();
    rsp_delay = 1;
    wait_req(10, 1'b0);
    chk("rst_mid_old_addr", imem_req_addr, 32'h404);
    next();
    rst = 1'b1;
    next();
    rst       = 1'b0;
    rsp_delay = 0;
    smp();
    chk("rst_mid_rsp_ignored", {31'b0, instr_valid}, 32'd0);
    chk("rst_mid_no_req", {31'b0, imem_req_valid}, 32'd0);
    next(); smp();
    chk("rst_mid_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_mid_req_addr", imem_req_addr, 32'h0);
    wait_valid(10);
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_instr", instr, 32'h0050_0093);

    next();
    next();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle controller and datapath.
- Owns the architectural PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request and valid response interface.
- Holds the fetched instruction in an output register and slices opcode/func3/func7/rd/rs1/rs2 for the controller and register file.
- Accepts branch/jump redirects and a back-pressure stall from the datapath.

Parameters:
- AW, 32, PC and instruction-memory address width.
- DW, 32, instruction width; must be 32.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  AW  fetch byte address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  DW  fetched instruction word.
- redirect_valid  in  1  taken branch/jump; PC must change.
- redirect_pc  in  AW  redirect target.
- stall  in  1  datapath cannot consume instr this cycle.
- instr_valid  out  1  instr/pc hold a live instruction.
- instr  out  DW  registered instruction.
- pc  out  AW  address of instr.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].

Behaviour:
- Reset values:
  - state = S_REQ_PENDING (no request in the reset cycle).
  - fetch_pc = RESET_PC.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - instr_valid = 0, instr = 32'h0000_0013 (NOP), pc = RESET_PC.
  - kill = 0.
- Reset mid-operation discards any in-flight response. Responses arriving after reset are ignored until a new request is accepted.
- States:
  - S_REQ: imem_req_valid = 1, imem_req_addr = req_addr_q. On imem_req_ready, go to S_WAIT.
  - S_WAIT: wait for imem_rsp_valid.
    - If kill = 1: drop the data, clear kill, go to S_REQ with req_addr_q = fetch_pc.
    - Otherwise: instr <= imem_rsp_data, pc <= req_addr_q, instr_valid <= 1, go to S_OUT.
  - S_OUT: instr_valid = 1; instr and pc are stable while stall = 1.
    - Consume condition: stall = 0 and no redirect.
    - On consume: instr_valid <= 0, fetch_pc <= pc + 4, req_addr_q <= pc + 4, go to S_REQ.
- The first cycle after rst deasserts enters S_REQ with req_addr_q = RESET_PC.
- Request stability: once imem_req_valid = 1, imem_req_addr stays constant until imem_req_ready is sampled high. A redirect never changes an un-accepted address.
- Redirect rules (redirect_pc[1:0] forced to 2'b00; fetch_pc <= aligned redirect_pc in every case):
  - In S_OUT: instr_valid <= 0 next cycle, req_addr_q <= target, go to S_REQ. Redirect has priority over stall.
  - In S_WAIT: kill <= 1, unless imem_rsp_valid arrives in the same cycle. In that case the response is dropped directly and the next state is S_REQ with the target.
  - In S_REQ: kill <= 1. The pending request completes normally and its response is dropped; the next request uses the target.
  - A second redirect before the dropped response returns overwrites fetch_pc; kill stays 1 (single outstanding request).
- imem_rsp_valid outside S_WAIT is ignored.
- PC arithmetic is modulo 2^AW: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Field outputs are combinational slices of the instr register and are valid only when instr_valid = 1.
- Throughput with a zero-wait memory (ready = 1, response one cycle after accept): one instruction every 3 cycles.
- Latency from rst release to the first instr_valid: 3 cycles.

Test Plan:
- Reset then zero-wait memory returning 32'h0050_0093 at address 0:
  - imem_req_addr = 0 in cycle 1; instr_valid = 1 in cycle 3.
  - opcode = 7'h13, rd = 1, rs1 = 0, func3 = 0, pc = 0.
  - Next request at addr 4.
- Hold stall = 1 for 5 cycles with instr_valid = 1:
  - instr and pc unchanged; no new request issued.
  - After stall drops, the next request is at pc + 4.
- imem_req_ready low for 4 cycles: imem_req_valid stays high and imem_req_addr stays 32'h8 throughout.
- Redirect to 32'h0000_0102 during S_WAIT:
  - The returning response is discarded; instr_valid stays 0.
  - The next request is at 32'h0000_0100; instr_valid then shows pc = 32'h100.
- Redirect and imem_rsp_valid in the same S_WAIT cycle: response dropped, next imem_req_addr = redirect target, no spurious instr_valid.
- RESET_PC = 32'hFFFF_FFFC, consume one instruction: next imem_req_addr = 32'h0000_0000.
- Assert rst while in S_WAIT, then deliver imem_rsp_valid: ignored; instr_valid = 0 and the first post-reset request goes to RESET_PC.
